// File: rtl/mem_resp_pkg.sv
// Shared types for the memory responder.
//   mem_resp_state_e : one-hot FSM encoding (IDLE, WAIT, RESP)
//   mem_resp_port_e  : which requester a transaction belongs to
//   WCNT_W           : width of the wait-state counter
package mem_resp_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    WAIT = 3'b010,
    RESP = 3'b100
  } mem_resp_state_e;

  typedef enum logic {
    PORT_INS = 1'b0,
    PORT_DA  = 1'b1
  } mem_resp_port_e;

  localparam int unsigned WCNT_W = 4;

endpackage

// File: rtl/mem_resp_array.sv
// DEPTH x DATA_W word storage: one synchronous write port, one combinational
// read port. Addresses >= DEPTH are ignored on write and read back as zero.
// Contents are deliberately not reset.
//   clk    : write clock
//   we     : write strobe
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational)
module mem_resp_array #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic wr_in_range;
  logic rd_in_range;

  always_comb begin
    wr_in_range = 32'(waddr) < DEPTH;
    rd_in_range = 32'(raddr) < DEPTH;
  end

  always_ff @(posedge clk) begin
    if (we && wr_in_range) begin
      mem_q[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_in_range) begin
      rdata = mem_q[raddr[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: serves instruction fetches and data read/write
// strobes against one internal single-port array, after WAIT_CYCLES wait
// states, plus a preload port usable while idle.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   ins_req/ins_addr    : instruction read request (level)
//   da_req/da_we/...    : data request (level), write when da_we=1
//   init_we/addr/data   : preload write, honoured in IDLE with top priority
//   ins_rdata/ins_ready : fetched word (held) and one-cycle valid pulse
//   da_rdata/da_ready   : data result (held) and one-cycle done pulse
//   busy                : FSM not in IDLE
//   oob_err             : pulses with ready when the latched address >= DEPTH
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ins_req,
  input  logic [ADDR_W-1:0] ins_addr,
  input  logic              da_req,
  input  logic              da_we,
  input  logic [ADDR_W-1:0] da_addr,
  input  logic [DATA_W-1:0] da_wdata,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  output logic [DATA_W-1:0] ins_rdata,
  output logic              ins_ready,
  output logic [DATA_W-1:0] da_rdata,
  output logic              da_ready,
  output logic              busy,
  output logic              oob_err
);

  localparam logic [WCNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : WCNT_W'(WAIT_CYCLES - 1);

  mem_resp_state_e   state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  mem_resp_port_e    port_q, port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ins_rdata_q, ins_rdata_d;
  logic [DATA_W-1:0] da_rdata_q, da_rdata_d;

  // Transaction view: live request while accepting in IDLE (needed when
  // WAIT_CYCLES=0 commits on the accepting edge), latched copy otherwise.
  mem_resp_port_e    cur_port;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_we;
  logic [DATA_W-1:0] cur_wdata;
  logic              go_resp;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  mem_resp_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (cur_addr),
    .rdata (arr_rdata)
  );

  always_comb begin
    cur_port  = port_q;
    cur_addr  = addr_q;
    cur_we    = we_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_port  = da_req ? PORT_DA : PORT_INS;
      cur_addr  = da_req ? da_addr : ins_addr;
      cur_we    = da_req & da_we;
      cur_wdata = da_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    port_d      = port_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    ins_rdata_d = ins_rdata_q;
    da_rdata_d  = da_rdata_q;
    go_resp     = 1'b0;
    arr_we      = 1'b0;
    arr_waddr   = cur_addr;
    arr_wdata   = cur_wdata;

    unique case (state_q)
      IDLE: begin
        if (init_we) begin
          arr_we    = 1'b1;
          arr_waddr = init_addr;
          arr_wdata = init_data;
        end else if (da_req || ins_req) begin
          port_d  = cur_port;
          addr_d  = cur_addr;
          we_d    = cur_we;
          wdata_d = cur_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Commit happens on the edge into RESP; the array drops OOB writes
    // and returns zero for OOB reads.
    if (go_resp) begin
      if (cur_port == PORT_DA) begin
        if (cur_we) begin
          arr_we     = 1'b1;
          da_rdata_d = cur_wdata;
        end else begin
          da_rdata_d = arr_rdata;
        end
      end else begin
        ins_rdata_d = arr_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      port_q      <= PORT_INS;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      ins_rdata_q <= '0;
      da_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      port_q      <= port_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      ins_rdata_q <= ins_rdata_d;
      da_rdata_q  <= da_rdata_d;
    end
  end

  always_comb begin
    ins_rdata = ins_rdata_q;
    da_rdata  = da_rdata_q;
    busy      = (state_q != IDLE);
    ins_ready = (state_q == RESP) && (port_q == PORT_INS);
    da_ready  = (state_q == RESP) && (port_q == PORT_DA);
    oob_err   = (state_q == RESP) && !(32'(addr_q) < DEPTH);
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU control FSM.
- Serves instruction-fetch and data read/write strobes against one internal single-port word array.
- Returns per-port ready pulses and registered read data after a programmable number of wait states.
- Sits between the control/datapath and storage; also exposes a preload port for program/data initialisation.

Parameters:
- ADDR_W, 5, address width of both request ports.
- DATA_W, 8, word width (3-bit opcode + 5-bit operand).
- DEPTH, 32, number of implemented words; must be ≤ 2**ADDR_W.
- WAIT_CYCLES, 1, idle cycles between acceptance and response (0..15).

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- ins_req, input, 1, instruction read request (level, driven by memIns_en).
- ins_addr, input, ADDR_W, instruction address (PC).
- da_req, input, 1, data request (level, driven by memDa_en or memDa_we).
- da_we, input, 1, 1 = data write, 0 = data read.
- da_addr, input, ADDR_W, data address (operand field).
- da_wdata, input, DATA_W, write data (accumulator).
- init_we, input, 1, preload write strobe.
- init_addr, input, ADDR_W, preload address.
- init_data, input, DATA_W, preload data.
- ins_rdata, output, DATA_W, fetched instruction, held until the next instruction response.
- ins_ready, output, 1, one-cycle pulse: ins_rdata valid.
- da_rdata, output, DATA_W, data read result, held until the next data response.
- da_ready, output, 1, one-cycle pulse: data transaction complete.
- busy, output, 1, high whenever state is not IDLE.
- oob_err, output, 1, one-cycle pulse with ready when the latched address ≥ DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, wait counter=0, all outputs 0 including both rdata registers. Array contents are not reset.
- Reset mid-transaction aborts it: no ready pulse is issued, and a write not yet committed is dropped.
- FSM is one-hot: IDLE, WAIT, RESP.
- IDLE, priority order:
  - init_we: writes the array at init_addr (ignored if ≥ DEPTH); the state stays IDLE and requests wait.
  - da_req: accepted.
  - ins_req: accepted; a simultaneous ins_req stays pending if da_req also wins.
- On acceptance, latch port select, address, we and wdata. Later changes or deassertion of req/addr/wdata do not affect the transaction.
- Accept → WAIT with counter=WAIT_CYCLES-1, or → RESP directly when WAIT_CYCLES=0.
- WAIT: counter decrements each cycle; at 0 go to RESP.
- Entering RESP (clock edge), by transaction type:
  - Read: the rdata register of the served port loads array[addr].
  - Write: the array is updated and da_rdata loads da_wdata (write-through).
- RESP lasts one cycle. The served port's ready is high for that cycle only; the other port's ready stays 0. Next state is IDLE.
- Latency: ready is high exactly WAIT_CYCLES+1 cycles after the accepting edge. Minimum request-to-request period is WAIT_CYCLES+2 cycles.
- Requests are level-sensitive: a request still high in IDLE after its response is served again. The requester must drop req in the cycle after ready.
- Out of range (latched addr ≥ DEPTH): read returns 0, write is suppressed, oob_err pulses with ready.
- The array is read combinationally from the latched address; writes are synchronous. There is no read-during-write hazard because there is only one port.

Decomposition:
- Package mem_resp_pkg: one-hot state typedef mem_resp_state_e (IDLE=3'b001, WAIT=3'b010, RESP=3'b100); port-select typedef (PORT_INS, PORT_DA); WAIT counter width constant (4).
- Sub-module mem_resp_array: DEPTH x DATA_W storage with one synchronous write port and one combinational read port. The top-level muxes init vs transaction writes into it.

Test Plan (WAIT_CYCLES=1 unless stated):
- Preload: init_we writes 0xA5 @3 in IDLE; then ins_req with ins_addr=3 → ins_ready pulses 2 cycles after acceptance, ins_rdata=0xA5, da_ready stays 0.
- Data write then read: da_req, da_we=1, da_addr=7, da_wdata=0x3C → da_ready pulses, da_rdata=0x3C. Then da_we=0, da_addr=7 → da_rdata=0x3C, busy high for 2 cycles per transaction.
- Simultaneous: ins_req and da_req both high in IDLE → data served first; instruction served next; ins_ready rises exactly 3 cycles after da_ready.
- Mid-operation change: after acceptance of read @2 (content 0x11), switch da_addr to 9 and drop da_req → da_rdata=0x11, da_ready pulses once.
- Reset abort: write 0x77 @5 accepted, rst_n low during WAIT → no da_ready, all outputs 0; array[5] keeps its previous value (0x00 after preload).
- WAIT_CYCLES=0, DEPTH=24: read @30 → ready 1 cycle after acceptance, da_rdata=0, oob_err=1. Write @30 leaves array[6] and all others unchanged.
